// File: rtl/conv_addr_pkg.sv
// Shared constants and FSM state type for the 3x3 convolution address generator.
package conv_addr_pkg;
    localparam int IMG_W    = 64;
    localparam int IMG_H    = 64;
    localparam int AW       = 13;
    localparam int NUM_PASS = 3;
    localparam int KTAPS    = 9;
    localparam logic signed [AW-1:0] PAD_ADDR = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;
endpackage

// File: rtl/kernel_tap_decode.sv
// Maps (tap, row, col) to a neighbour address for a 3x3 window.
// CONV_ADDR_CLAMP_EN: clamp out-of-image neighbours to the edge instead of emitting PAD_ADDR.
module kernel_tap_decode
    import conv_addr_pkg::*;
#(
    parameter int IMG_W = conv_addr_pkg::IMG_W,
    parameter int IMG_H = conv_addr_pkg::IMG_H,
    parameter int AW    = conv_addr_pkg::AW,
    parameter int RW    = $clog2(IMG_H),
    parameter int CW    = $clog2(IMG_W)
) (
    input  logic [3:0]           tap_i,
    input  logic [RW-1:0]        row_i,
    input  logic [CW-1:0]        col_i,
    output logic                 in_bounds_o,
    output logic signed [AW-1:0] addr_o
);
    localparam logic signed [AW:0] ONE = (AW+1)'(1);
    localparam logic signed [AW:0] W_S = (AW+1)'(IMG_W);
    localparam logic signed [AW:0] H_S = (AW+1)'(IMG_H);

    logic signed [AW:0]   dr, dc, nr, nc, nr_c, nc_c;
    logic signed [AW-1:0] lin;

    always_comb begin
        dr = '0;
        dc = '0;
        case (tap_i)
            4'd0, 4'd1, 4'd2: dr = '1;
            4'd6, 4'd7, 4'd8: dr = ONE;
            default:          dr = '0;
        endcase
        case (tap_i)
            4'd0, 4'd3, 4'd6: dc = '1;
            4'd2, 4'd5, 4'd8: dc = ONE;
            default:          dc = '0;
        endcase

        nr = $signed((AW+1)'(row_i)) + dr;
        nc = $signed((AW+1)'(col_i)) + dc;
        in_bounds_o = !nr[AW] && (nr < H_S) && !nc[AW] && (nc < W_S);

`ifdef CONV_ADDR_CLAMP_EN
        nr_c = nr[AW] ? '0 : ((nr >= H_S) ? H_S - ONE : nr);
        nc_c = nc[AW] ? '0 : ((nc >= W_S) ? W_S - ONE : nc);
        lin  = AW'(nr_c * W_S + nc_c);
        addr_o = lin;
`else
        nr_c = nr;
        nc_c = nc;
        lin  = AW'(nr_c * W_S + nc_c);
        addr_o = in_bounds_o ? lin : AW'(PAD_ADDR);
`endif
    end
endmodule

// File: rtl/conv_addr_gen.sv
// Raster-scan 3x3 neighbour address generator with valid/ready output and multi-pass count.
// CONV_ADDR_CLAMP_EN selects edge clamping in the tap decoder instead of -1 padding.
module conv_addr_gen
    import conv_addr_pkg::*;
#(
    parameter int IMG_W    = conv_addr_pkg::IMG_W,
    parameter int IMG_H    = conv_addr_pkg::IMG_H,
    parameter int AW       = conv_addr_pkg::AW,
    parameter int NUM_PASS = conv_addr_pkg::NUM_PASS
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 start_i,
    input  logic                 out_ready_i,
    output logic                 out_valid_o,
    output logic signed [AW-1:0] addr_o,
    output logic [1:0]           cnt_o,
    output logic [3:0]           kidx_o,
    output logic                 last_tap_o,
    output logic                 busy_o,
    output logic                 done_o
);
    // state | meaning
    // IDLE  | waiting for start, outputs quiet
    // RUN   | presenting one tap per accepted transfer
    // DONE  | one-cycle completion pulse
    localparam int RW = $clog2(IMG_H);
    localparam int CW = $clog2(IMG_W);
    localparam logic [3:0]    TAP_LAST  = 4'(KTAPS - 1);
    localparam logic [CW-1:0] COL_LAST  = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_H - 1);
    localparam logic [1:0]    PASS_LAST = 2'(NUM_PASS - 1);

    state_t        state_q, state_d;
    logic [3:0]    tap_q, tap_d;
    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic [1:0]    pass_q, pass_d;

    logic                 run, end_tap, end_col, end_row, end_pass;
    logic                 dec_in_bounds;
    logic signed [AW-1:0] dec_addr;

    kernel_tap_decode #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H),
        .AW    (AW),
        .RW    (RW),
        .CW    (CW)
    ) u_dec (
        .tap_i       (tap_q),
        .row_i       (row_q),
        .col_i       (col_q),
        .in_bounds_o (dec_in_bounds),
        .addr_o      (dec_addr)
    );

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            tap_q   <= '0;
            col_q   <= '0;
            row_q   <= '0;
            pass_q  <= '0;
        end else begin
            state_q <= state_d;
            tap_q   <= tap_d;
            col_q   <= col_d;
            row_q   <= row_d;
            pass_q  <= pass_d;
        end
    end

    assign run      = (state_q == RUN);
    assign end_tap  = (tap_q == TAP_LAST);
    assign end_col  = (col_q == COL_LAST);
    assign end_row  = (row_q == ROW_LAST);
    assign end_pass = (pass_q == PASS_LAST);

    always_comb begin
        state_d = state_q;
        tap_d   = tap_q;
        col_d   = col_q;
        row_d   = row_q;
        pass_d  = pass_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = RUN;
                    tap_d   = '0;
                    col_d   = '0;
                    row_d   = '0;
                    pass_d  = '0;
                end
            end
            RUN: begin
                if (out_ready_i) begin
                    tap_d = tap_q + 4'd1;
                    if (end_tap) begin
                        tap_d = '0;
                        col_d = col_q + CW'(1);
                        if (end_col) begin
                            col_d = '0;
                            row_d = row_q + RW'(1);
                            if (end_row) begin
                                row_d  = '0;
                                pass_d = pass_q + 2'd1;
                                if (end_pass) begin
                                    pass_d  = '0;
                                    state_d = DONE;
                                end
                            end
                        end
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are forced to zero outside RUN so reset and idle never show a pad address.
    assign out_valid_o = run;
    assign busy_o      = run;
    assign done_o      = (state_q == DONE);
    assign addr_o      = run ? dec_addr : '0;
    assign cnt_o       = run ? pass_q : 2'd0;
    assign kidx_o      = run ? tap_q : 4'd0;
    assign last_tap_o  = run && end_tap && end_col && end_row && end_pass;

    always_comb begin
        if (run && !dec_in_bounds) begin
`ifdef CONV_ADDR_CLAMP_EN
            assert (!dec_addr[AW-1]);
`else
            assert (dec_addr == AW'(PAD_ADDR));
`endif
        end
    end
endmodule

// File: tb/tb_conv_addr_gen.sv
// Randomised-backpressure bench for conv_addr_gen against an arithmetic reference of the scan order.
module tb_conv_addr_gen;
    localparam int TW       = 64;
    localparam int TH       = 8;
    localparam int TAW      = 13;
    localparam int TNP      = 3;
    localparam int KT       = 9;
    localparam int PER_PASS = TW * TH * KT;
    localparam int TOTAL    = PER_PASS * TNP;
    localparam int BUDGET   = 60000;

    logic                  clk_i = 1'b0;
    logic                  reset_i;
    logic                  start_i;
    logic                  out_ready_i;
    logic                  out_valid_o;
    logic signed [TAW-1:0] addr_o;
    logic [1:0]            cnt_o;
    logic [3:0]            kidx_o;
    logic                  last_tap_o;
    logic                  busy_o;
    logic                  done_o;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string tag;
        int    idx;
        int    addr;
    } dir_t;
    dir_t dir_q[$];

    conv_addr_gen #(
        .IMG_W    (TW),
        .IMG_H    (TH),
        .AW       (TAW),
        .NUM_PASS (TNP)
    ) dut (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .start_i     (start_i),
        .out_ready_i (out_ready_i),
        .out_valid_o (out_valid_o),
        .addr_o      (addr_o),
        .cnt_o       (cnt_o),
        .kidx_o      (kidx_o),
        .last_tap_o  (last_tap_o),
        .busy_o      (busy_o),
        .done_o      (done_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d", tag, got, exp);
        end
    endtask

    // Transfer n of the scan -> neighbour address, straight from the window geometry.
    function automatic int ref_addr(input int n);
        int rem, ctr, t, r, c, nr, nc;
        rem = n % PER_PASS;
        ctr = rem / KT;
        t   = rem % KT;
        r   = ctr / TW;
        c   = ctr % TW;
        nr  = r + t / 3 - 1;
        nc  = c + t % 3 - 1;
`ifdef CONV_ADDR_CLAMP_EN
        if (nr < 0) nr = 0;
        if (nr > TH - 1) nr = TH - 1;
        if (nc < 0) nc = 0;
        if (nc > TW - 1) nc = TW - 1;
        return nr * TW + nc;
`else
        if (nr < 0 || nr >= TH || nc < 0 || nc >= TW) return -1;
        return nr * TW + nc;
`endif
    endfunction

    task automatic check_tap(input int n);
        chk("addr", int'(addr_o), ref_addr(n));
        chk("cnt", int'(cnt_o), n / PER_PASS);
        chk("kidx", int'(kidx_o), (n % PER_PASS) % KT);
        chk("last_tap", int'(last_tap_o), (n == TOTAL - 1) ? 1 : 0);
`ifdef CONV_ADDR_CLAMP_EN
        chk("nonneg", int'(addr_o[TAW-1]), 0);
`endif
        foreach (dir_q[i])
            if (dir_q[i].idx == n) chk(dir_q[i].tag, int'(addr_o), dir_q[i].addr);
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_valid"}, int'(out_valid_o), 0);
        chk({tag, "_busy"}, int'(busy_o), 0);
        chk({tag, "_done"}, int'(done_o), 0);
        chk({tag, "_addr"}, int'(addr_o), 0);
        chk({tag, "_cnt"}, int'(cnt_o), 0);
        chk({tag, "_kidx"}, int'(kidx_o), 0);
        chk({tag, "_last"}, int'(last_tap_o), 0);
    endtask

    task automatic run_scan(input int rst_at);
        int n, cyc, dones;
        bit rdy;
        n = 0;
        cyc = 0;
        dones = 0;
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        chk("first_valid", int'(out_valid_o), 1);
        while (n < TOTAL && n != rst_at && cyc < BUDGET) begin
            chk("valid", int'(out_valid_o), 1);
            dones += int'(done_o);
            if (out_valid_o) check_tap(n);
            rdy = ($urandom_range(0, 3) != 0);
            out_ready_i = rdy;
            start_i = (rst_at < 0) && ($urandom_range(0, 15) == 0);
            if (out_valid_o && rdy) n++;
            @(negedge clk_i);
            cyc++;
        end
        start_i = 1'b0;
        chk("done_during_run", dones, 0);
        if (rst_at >= 0) begin
            chk("reset_point", n, rst_at);
            reset_i = 1'b1;
            #1;
            check_idle("async_rst");
            @(negedge clk_i);
            reset_i = 1'b0;
            dones = 0;
            repeat (20) begin
                @(negedge clk_i);
                dones += int'(done_o) + int'(out_valid_o);
            end
            chk("quiet_after_rst", dones, 0);
            start_i = 1'b1;
            @(negedge clk_i);
            start_i = 1'b0;
            chk("restart_valid", int'(out_valid_o), 1);
`ifdef CONV_ADDR_CLAMP_EN
            chk("restart_addr", int'(addr_o), 0);
`else
            chk("restart_addr", int'(addr_o), -1);
`endif
            check_tap(0);
        end else begin
            chk("xfer_count", n, TOTAL);
            chk("done_pulse", int'(done_o), 1);
            chk("done_valid", int'(out_valid_o), 0);
            chk("done_busy", int'(busy_o), 0);
            start_i = 1'b1;
            @(negedge clk_i);
            start_i = 1'b0;
            chk("done_once", int'(done_o), 0);
            repeat (3) @(negedge clk_i);
            check_idle("after_done");
        end
    endtask

    initial begin
        int c00[9];
`ifdef CONV_ADDR_CLAMP_EN
        c00 = '{0, 0, 1, 0, 0, 1, 64, 64, 65};
        dir_q.push_back('{"far_t8", 511 * KT + 8, 511});
`else
        c00 = '{-1, -1, -1, -1, 0, 1, -1, 64, 65};
        dir_q.push_back('{"far_t8", 511 * KT + 8, -1});
`endif
        for (int t = 0; t < 9; t++) dir_q.push_back('{"corner00", t, c00[t]});
        dir_q.push_back('{"mid_t0", 330 * KT + 0, 265});
        dir_q.push_back('{"mid_t4", 330 * KT + 4, 330});
        dir_q.push_back('{"mid_t8", 330 * KT + 8, 395});
        dir_q.push_back('{"far_t0", 511 * KT + 0, 446});
        dir_q.push_back('{"far_t4", 511 * KT + 4, 511});

        reset_i = 1'b1;
        start_i = 1'b0;
        out_ready_i = 1'b0;
        repeat (3) @(negedge clk_i);
        check_idle("in_rst");
        reset_i = 1'b0;
        repeat (2) @(negedge clk_i);
        check_idle("post_rst");

        run_scan(-1);
        run_scan(5000);

        reset_i = 1'b1;
        @(negedge clk_i);
        reset_i = 1'b0;
        @(negedge clk_i);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
